// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory port:
// RV32 load/store funct3 codes, grant encoding and the alignment rule.
package mem_port_arbiter_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Also consumed by the hazard unit to see who owns the port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_DATA  = 2'd1,
    GNT_FETCH = 2'd2
  } gnt_e;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
    logic bad;
    case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = lsb[0];
      F3_LW:         bad = (lsb != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_fetch_resp_buf.sv
// One-entry registered fetch response buffer with a valid/ready handshake;
// a refill in the same cycle as a consume keeps the entry valid.
module fetch_resp_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              ready,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              valid,
  output logic [DATA_W-1:0] rdata
);

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;

  // Stage p1: word captured at the edge following the fetch grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= rdata_in;
    end else if (ready && vld_p1) begin
      vld_p1  <= 1'b0;
    end
  end

  assign valid = vld_p1;
  assign rdata = data_p1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single unified memory between instruction fetch and the
// load/store unit: data wins by default, a burst counter bounds fetch starvation.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_BURST = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  gnt_e             gnt;
  logic [CNT_W-1:0] burst_cnt;
  logic             fetch_ok;
  logic             force_fetch;
  logic             misaligned;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^if_addr[1:0];

  // Stage p0: combinational grant, one winner per cycle, nothing during reset.
  always_comb begin
    fetch_ok    = !if_valid || if_ready;
    force_fetch = if_req && (burst_cnt == CNT_MAX) && fetch_ok;
    misaligned  = is_misaligned(d_funct3, d_addr[1:0]);
    gnt         = GNT_NONE;
    if (rst_n) begin
      if (d_req && !force_fetch)  gnt = GNT_DATA;
      else if (if_req && fetch_ok) gnt = GNT_FETCH;
    end
  end

  always_comb begin
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    d_err      = 1'b0;
    d_rdata    = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = F3_LW;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (gnt)
      GNT_DATA: begin
        d_gnt      = 1'b1;
        d_err      = misaligned;
        d_rdata    = misaligned ? 32'd0 : mem_rdata;
        mem_read   = !d_we;
        mem_write  = d_we && !misaligned;
        mem_funct3 = d_funct3;
        mem_addr   = d_addr;
        mem_wdata  = d_wdata;
      end
      GNT_FETCH: begin
        if_gnt   = 1'b1;
        mem_addr = {if_addr[ADDR_W-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  // Stage p1: starvation counter, only meaningful while a fetch is waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (gnt == GNT_FETCH || !if_req) begin
      burst_cnt <= '0;
    end else if (gnt == GNT_DATA) begin
      burst_cnt <= sat_inc(burst_cnt);
    end
  end

  fetch_resp_buf #(.DATA_W(32)) u_fetch_resp_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gnt == GNT_FETCH),
    .ready    (if_ready),
    .rdata_in (mem_rdata),
    .valid    (if_valid),
    .rdata    (if_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-addressed 256-byte memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_valid, if_ready;
  logic [7:0]  if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_gnt, d_err;
  logic [2:0]  d_funct3;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:255];
  logic [7:0] a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .MAX_BURST(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: addresses wrap mod 256, little-endian, raw word when not reading.
  assign a1 = mem_addr + 8'd1;
  assign a2 = mem_addr + 8'd2;
  assign a3 = mem_addr + 8'd3;
  assign b0 = mem[mem_addr];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    mem_rdata = {b3, b2, b1, b0};
    if (mem_read) begin
      case (mem_funct3)
        3'b000:  mem_rdata = {{24{b0[7]}}, b0};
        3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
        3'b100:  mem_rdata = {24'd0, b0};
        3'b101:  mem_rdata = {16'd0, b1, b0};
        default: mem_rdata = {b3, b2, b1, b0};
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_funct3 != 3'b000) mem[a1] <= mem_wdata[15:8];
      if (mem_funct3 != 3'b000 && mem_funct3 != 3'b001) begin
        mem[a2] <= mem_wdata[23:16];
        mem[a3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input int addr, input logic [31:0] w);
    mem[addr]   = w[7:0];
    mem[addr+1] = w[15:8];
    mem[addr+2] = w[23:16];
    mem[addr+3] = w[31:24];
  endtask

  task automatic drive_data(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                            input logic [31:0] wdata);
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
  endtask

  logic [1:0] exp_gnt [5];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    put_word(0,    32'h00000033);
    put_word(4,    32'h04002083);
    put_word(8,    32'h04402103);
    put_word(16,   32'h00100093);
    put_word(8'h40, 32'h11223344);
    put_word(8'hFC, 32'hDEADBEEF);

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_ready = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'b010; d_addr = '0; d_wdata = '0;
    tick(); tick();

    // Reset: registered state cleared, grants suppressed.
    check_eq("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_burst", 32'(dut.burst_cnt), 32'd0);
    if_req = 1'b1; drive_data(1'b1, 3'b010, 8'h40, 32'h99999999);
    #1;
    check_eq("rst_gnts", {29'd0, if_gnt, d_gnt, d_err}, 32'd0);
    check_eq("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    tick();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; rst_n = 1'b1;
    #1;
    check_eq("idle_port", {mem_read, mem_write, mem_funct3, mem_addr, 8'd0, mem_wdata[11:0]},
             {2'b00, 3'b010, 8'h00, 8'd0, 12'd0});

    // Fetch-only stream.
    if_req = 1'b1; if_ready = 1'b1; if_addr = 8'd0;
    #1;
    check_eq("f0_gnt", {mem_read, if_gnt, mem_funct3, mem_addr}, {1'b0, 1'b1, 3'b010, 8'd0});
    tick();
    check_eq("f0_data", {if_valid, if_rdata[30:0]}, {1'b1, 31'h00000033});
    if_addr = 8'd4;
    #1;
    check_eq("f1_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    check_eq("f1_data", if_rdata, 32'h04002083);
    if_addr = 8'd9;
    #1;
    check_eq("f2_addr", {24'd0, mem_addr}, 32'd8);
    tick();
    check_eq("f2_data", if_rdata, 32'h04402103);
    check_eq("f2_valid", {31'd0, if_valid}, 32'd1);
    if_req = 1'b0;
    tick();
    check_eq("f_drain", {31'd0, if_valid}, 32'd0);

    // Contention with MAX_BURST = 3: D, D, D, F, D.
    exp_gnt = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    if_req = 1'b1; if_addr = 8'd16; drive_data(1'b0, 3'b010, 8'h40, 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("cont_gnt%0d", i), {30'd0, d_gnt, if_gnt}, {30'd0, exp_gnt[i]});
      if (i == 0) check_eq("cont_rdata", d_rdata, 32'h11223344);
      tick();
      if (i == 2) check_eq("cont_burst_sat", 32'(dut.burst_cnt), 32'd3);
      if (i == 3) check_eq("cont_burst_clr", 32'(dut.burst_cnt), 32'd0);
    end
    check_eq("cont_fetch_data", if_rdata, 32'h00100093);
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // Store then load.
    drive_data(1'b1, 3'b010, 8'd76, 32'h000000AB);
    #1;
    check_eq("sw_port", {d_gnt, d_err, mem_write, mem_addr}, {1'b1, 1'b0, 1'b1, 8'd76});
    tick();
    drive_data(1'b0, 3'b010, 8'd76, 32'd0);
    #1;
    check_eq("lw_nowrite", {30'd0, mem_read, mem_write}, 32'd2);
    check_eq("lw_rdata", d_rdata, 32'h000000AB);

    // Misaligned and alignment boundary cases.
    drive_data(1'b0, 3'b001, 8'h41, 32'd0);
    #1;
    check_eq("lh41", {d_gnt, d_err, d_rdata[29:0]}, {1'b1, 1'b1, 30'd0});
    drive_data(1'b1, 3'b010, 8'h42, 32'hFFFFFFFF);
    #1;
    check_eq("sw42", {30'd0, d_err, mem_write}, 32'd2);
    tick();
    drive_data(1'b0, 3'b010, 8'h40, 32'd0);
    #1;
    check_eq("mem40_kept", d_rdata, 32'h11223344);
    drive_data(1'b0, 3'b010, 8'hFC, 32'd0);
    #1;
    check_eq("lwFC", {d_err, d_rdata[30:0]}, {1'b0, 31'h5EADBEEF});
    drive_data(1'b0, 3'b000, 8'h41, 32'd0);
    #1;
    check_eq("lb41", {d_err, d_rdata[30:0]}, {1'b0, 31'h00000033});
    drive_data(1'b0, 3'b101, 8'h42, 32'd0);
    #1;
    check_eq("lhu42", {d_err, d_rdata[30:0]}, {1'b0, 31'h00001122});
    drive_data(1'b0, 3'b011, 8'h00, 32'd0);
    #1;
    check_eq("f3_011", {31'd0, d_err}, 32'd1);
    d_req = 1'b0;
    tick();

    // Backpressure.
    if_req = 1'b1; if_ready = 1'b0; if_addr = 8'd0;
    tick();
    check_eq("bp_first", if_rdata, 32'h00000033);
    if_addr = 8'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("bp_hold%0d", i), {if_valid, if_gnt, if_rdata[29:0]},
               {1'b1, 1'b0, 30'h00000033});
      tick();
    end
    if_ready = 1'b1;
    #1;
    check_eq("bp_release_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    check_eq("bp_next", if_rdata, 32'h04002083);

    // Reset mid-operation: build burst_cnt and a held response first.
    if_ready = 1'b0; if_addr = 8'd8; drive_data(1'b0, 3'b010, 8'h40, 32'd0);
    #1;
    check_eq("pre_rst_gnt", {30'd0, d_gnt, if_gnt}, 32'd2);
    tick();
    check_eq("pre_rst_burst", 32'(dut.burst_cnt), 32'd1);
    rst_n = 1'b0; drive_data(1'b1, 3'b010, 8'h40, 32'h00000055);
    #1;
    check_eq("rst_store", {30'd0, d_gnt, mem_write}, 32'd0);
    tick();
    rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;
    check_eq("post_rst", {if_valid, 29'd0, dut.burst_cnt}, 32'd0);
    check_eq("post_rst_rdata", if_rdata, 32'd0);
    drive_data(1'b0, 3'b010, 8'h40, 32'd0);
    #1;
    check_eq("post_rst_mem40", d_rdata, 32'h11223344);
    d_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified 256-byte instruction/data memory (`Mem`) between the fetch stage and the MEM-stage load/store unit of the pipelined RV32 core. Data accesses win by default, and a burst counter bounds fetch starvation. Fetch responses come back through a one-entry registered buffer with a valid/ready handshake. Misaligned halfword and word accesses are rejected before they reach the memory.

## Interface
Parameters:
- `ADDR_W`, 8: byte-address width of the memory port.
- `MAX_BURST`, 3: consecutive data grants allowed while a fetch is pending; must be ≥ 1.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `if_req` in 1: fetch request.
- `if_addr` in ADDR_W: fetch byte address; bits [1:0] are ignored and forced to 0.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_valid` out 1: `if_rdata` holds an instruction.
- `if_rdata` out 32: fetched instruction.
- `if_ready` in 1: fetch stage consumes `if_rdata` this cycle.
- `d_req` in 1: load/store request.
- `d_we` in 1: 1 for store, 0 for load.
- `d_funct3` in 3: RV32 load/store funct3.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in 32: store data.
- `d_gnt` out 1: data access performed this cycle.
- `d_rdata` out 32: load result, valid in the same cycle as `d_gnt && !d_we`.
- `d_err` out 1: misaligned access; pulses together with `d_gnt`.
- `mem_read` out 1: drives `Mem.MemRead`.
- `mem_write` out 1: drives `Mem.MemWrite`.
- `mem_funct3` out 3: drives `Mem.funct3`.
- `mem_addr` out ADDR_W: drives `Mem.addr`.
- `mem_wdata` out 32: drives `Mem.data_in`.
- `mem_rdata` in 32: from `Mem.data_out`.

## Operation
- Grant (combinational, one winner per cycle):
  - `force_fetch = if_req && burst_cnt == MAX_BURST && fetch_ok`.
  - `fetch_ok = !if_valid || if_ready`.
  - Data is granted if `d_req && !force_fetch`.
  - Otherwise fetch is granted if `if_req && fetch_ok`.
  - Otherwise nothing is granted.
- Data grant:
  - `mem_read = !d_we`; `mem_funct3 = d_funct3`; `mem_addr = d_addr`; `d_rdata = mem_rdata`.
  - `mem_write = d_we && !misaligned && rst_n`.
  - `misaligned`: for funct3 000/100, never; for 001/101, `d_addr[0]`; for 010, `d_addr[1:0] != 0`; for any other funct3, always.
  - `d_err = misaligned`. A misaligned access still receives `d_gnt`; it performs no write and returns `d_rdata = 0`.
- Fetch grant:
  - `mem_read = 0` (memory returns the raw word); `mem_funct3 = 010`; `mem_addr = {if_addr[ADDR_W-1:2], 2'b00}`.
  - At the clock edge: `if_rdata <= mem_rdata`, `if_valid <= 1`.
- Idle port (no grant): `mem_read = 0`, `mem_write = 0`, `mem_addr = 0`, `mem_wdata = 0`, `mem_funct3 = 010`.
- `burst_cnt` (width `$clog2(MAX_BURST+1)`):
  - Cleared to 0 on a fetch grant or whenever `if_req = 0`.
  - Otherwise incremented on each data grant, saturating at MAX_BURST.
- Fetch buffer:
  - `if_valid` clears when `if_ready && if_valid` and there is no fetch grant that cycle.
  - Consume and refill in the same cycle give back-to-back valid data.
- Address wrap: the memory wraps `addr+k` modulo 256. A word access at 0xFC is aligned and legal. No access can wrap, because misaligned accesses are already rejected.

## Timing
- Data access latency is 0: grant, load data and `d_err` all appear in the request cycle. A store commits at the following rising edge.
- Fetch latency is 1: `if_valid`/`if_rdata` are registered and appear the cycle after `if_gnt`.
- Sustained fetch throughput is one word per cycle while `d_req = 0` and `if_ready = 1`.
- `if_rdata` and `if_valid` stay stable while `if_valid && !if_ready`.
- Reset (`rst_n = 0` at a rising edge):
  - `if_valid = 0`, `if_rdata = 0`, `burst_cnt = 0`.
  - Combinational grants are suppressed while `rst_n = 0`: `if_gnt = d_gnt = d_err = 0`, and `mem_write = mem_read = 0`.
  - A fetch response pending at reset is discarded.
  - A store requested in the reset cycle is not written.
- Simultaneous `if_req` and `d_req` with `burst_cnt < MAX_BURST`: data wins, and `burst_cnt` increments.

## Structure
- Shared defines file:
  - funct3 constants `F3_LB=000`, `F3_LH=001`, `F3_LW=010`, `F3_LBU=100`, `F3_LHU=101`, `F3_SB/SH/SW`.
  - Grant encoding `GNT_NONE/GNT_DATA/GNT_FETCH` (2 bits), reused by the hazard unit.
- One sub-module, `fetch_resp_buf`: the one-entry valid/ready register holding `if_rdata`/`if_valid`.
- Grant logic, misalignment check and burst counter live in the top module.

## Test plan
- Fetch-only stream: `if_req = 1`, `if_ready = 1`, addrs 0, 4, 8 -> `if_valid` from cycle 1 with 0x00000033, 0x04002083, 0x04402103, one per cycle.
- Contention with MAX_BURST = 3: `if_req` and `d_req` held for 5 cycles -> grants are D, D, D, F, D; `burst_cnt` returns to 0 after F.
- Store then load: SW 0x000000AB at `d_addr` 76, then LW 76 -> `mem_write` for exactly 1 cycle, then `d_rdata = 0xAB` in the load's request cycle.
- Misaligned accesses:
  - LH at `d_addr` 0x41 -> `d_gnt = 1`, `d_err = 1`, `d_rdata = 0`.
  - SW at 0x42 -> `d_err = 1`, no write, memory at 0x40 unchanged.
  - LW at 0xFC -> `d_err = 0`.
- Backpressure: `if_ready = 0` with `if_valid = 1` -> no `if_gnt`, and `if_rdata` stays stable for 4 cycles. When `if_ready` rises, the next word is granted in the same cycle.
- Reset mid-operation: `rst_n = 0` during a store grant and with `if_valid = 1` -> no memory write; next cycle `if_valid = 0` and `burst_cnt = 0`.
